clk_div_multi: RTL and testbench
================================

# clk_div_multi

- Multi-channel, runtime-programmable clock divider.
- Generalises the fixed ÷2/÷4/÷6 divider to NUM_CH independent channels, each dividing clk by a per-channel integer divisor.
- Divisors are reprogrammed through a valid/ready config port and take effect glitch-free at the channel's next period boundary.
- Sits beside the fixed divider in the clocking utilities and drives enable/strobe-style derived clocks.

## Interface
- NUM_CH, 3: number of output channels (≥1).
- DIV_W, 4: divisor width in bits. Must satisfy 2·NUM_CH ≤ 2^DIV_W−1; elaboration error otherwise.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel. Values ≥ NUM_CH are accepted and discarded.
- cfg_div  in  DIV_W  new divisor D.
- cfg_ready  out  1  = ~pend[cfg_ch]. Combinational from cfg_ch. 1 for an out-of-range cfg_ch.
- div_out  out  NUM_CH  divided clock per channel.

## Operation
**Per-channel state**
- Active divisor Da, pending divisor Dp, pend flag, phase counter p (DIV_W bits), registered output.

**Reset (resetn=0 at an edge)**
- div_out=0, pend=0, p=idle.
- Da[i] = 2·(i+1), so the defaults are ÷2, ÷4, ÷6, …

**Write**
- Accepted at an edge where cfg_valid & cfg_ready & resetn.
- Sets Dp[cfg_ch]=cfg_div and pend[cfg_ch]=1.

**Period start**
- Defined as the first edge after reset release, or any edge where p wraps from Da−1 to 0.
- At a period start with pend=1: Da←Dp and pend←0 before the output is computed for that edge. The new divisor governs the whole new period.

**Enabled channel (Da ≥ 2)**
- At edge k of a period (k=0..Da−1), div_out=1 when k < ceil(Da/2), else 0.
- Even D gives 50% duty. Odd D is high one extra cycle (D=3 → 110, D=5 → 11100).

**Disabled channel (Da ∈ {0,1})**
- div_out held 0, p held idle.
- Every edge counts as a period start, so a pending write applies on the next edge and that edge drives div_out=1 (k=0).

**Boundary rules**
- Writing D<2 to a running channel: the current period finishes, then the output stays 0.
- Reset mid-period discards the partial period. The first edge after release starts a fresh period with div_out=1 on every enabled channel.
- Write coincident with resetn=0: dropped.
- Write to a channel with pend=1: stalled (cfg_ready=0) until the edge that applies Dp. cfg_ready rises the cycle after that edge.
- Channels are fully independent. Writes to other channels do not perturb phase.

## Timing
- div_out is registered directly from flops. No combinational path from inputs.
- Reset release latency: div_out rises at the first edge with resetn=1.
- Write-to-effect latency: from 1 edge (disabled channel) up to Da_old edges (accepted at k=0 of a running channel).
- cfg_ready is combinational only through the cfg_ch mux of pend.

## Configuration
- Macro: CLK_DIV_MULTI_TICK_EN.
- **Defined:** adds output port tick (NUM_CH bits).
  - tick[i] is registered and is 1 for exactly one cycle, in the same cycle div_out[i] rises, i.e. at each enabled period start.
  - Reset value 0. Never 1 on a disabled channel.
- **Undefined:** the tick port and its logic are absent. All other behaviour is identical.

## Structure
- Package clk_div_multi_pkg:
  - DIV_W-dependent divisor typedef.
  - Idle-phase constant.
  - Function returning the reset divisor for channel i (2·(i+1)).
  - Duty-threshold function ceil(D/2).
- Sub-module clk_div_channel:
  - Contains one channel's Da/Dp/pend/p/output (and tick).
  - Generated NUM_CH times.
  - Top level holds the config decode and the cfg_ready mux.

## Test plan
1. **Defaults (NUM_CH=3, DIV_W=4):** hold resetn=0 for 4 cycles → all outputs 0; release → ch0 1010…, ch1 11001100…, ch2 111000111000…, all high at the first edge.
2. **Mid-period reprogram:** write D=5 to ch1 at k=1 → ch1 finishes its 1100 period, then repeats 11100; ch0 and ch2 are unchanged.
3. **Disable/re-enable:** write D=0 to ch2 → output 0 after the current 111000; then write D=3 → high on the next edge, then 110 repeating.
4. **Reset mid-period:** pulse resetn=0 during k=2 of ch2 → all 0; on release all channels restart at k=0 with output 1.
5. **Back-to-back writes:** two writes to ch1 while it runs with D=6 → second write sees cfg_ready=0 until the period boundary; Dp takes the second value only after the first is applied. With the tick macro on, tick[1] pulses exactly at each ch1 rise.
6. **Write during reset:** cfg_valid=1, ch0, D=7 while resetn=0 → dropped; after release ch0 runs ÷2.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
`default_nettype none
// ============================================================================
// Package : clk_div_multi_pkg
// Brief   : Shared types, constants and helpers for the multi-channel divider.
// Rev     : 1.0
// ============================================================================
package clk_div_multi_pkg;

    localparam int unsigned c_DIV_W_DEF = 4;

    typedef logic [c_DIV_W_DEF-1:0] div_t;

    // All-ones is never a legal phase because the largest divisor is 2^DIV_W-1.
    localparam logic [31:0] c_PHASE_IDLE = '1;

    function automatic int unsigned reset_div(input int unsigned ch);
        return 2 * (ch + 1);
    endfunction

    function automatic int unsigned duty_threshold(input int unsigned d);
        return (d + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Interface : clk_div_multi_if
// Brief     : Divisor config port and divided outputs (tick with CLK_DIV_MULTI_TICK_EN).
// Rev       : 1.0
// ============================================================================
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DIV_W  = 4
);
    localparam int unsigned c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_valid;
    logic [c_CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] div_out;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic [NUM_CH-1:0] tick;
`endif

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, div_out
`ifdef CLK_DIV_MULTI_TICK_EN
        , input tick
`endif
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, div_out
`ifdef CLK_DIV_MULTI_TICK_EN
        , output tick
`endif
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_multi_channel.sv
`default_nettype none
// ============================================================================
// Module : clk_div_channel
// Brief  : One divider channel; divisor swaps only at period starts (tick with CLK_DIV_MULTI_TICK_EN).
// Rev    : 1.0
// ============================================================================
module clk_div_channel
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned RST_DIV = 2
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             wr_en,
    input  wire logic [DIV_W-1:0] wr_div,
    output logic                  pend,
    output logic                  div_out
`ifdef CLK_DIV_MULTI_TICK_EN
    ,
    output logic                  tick
`endif
);

    localparam logic [DIV_W-1:0] c_IDLE    = c_PHASE_IDLE[DIV_W-1:0];
    localparam logic [DIV_W-1:0] c_RST_DIV = DIV_W'(RST_DIV);

    logic [DIV_W-1:0] r_da;
    logic [DIV_W-1:0] r_dp;
    logic [DIV_W-1:0] r_p;
    logic             r_pend;
    logic             r_out;

    logic             w_start;
    logic             w_enabled;
    logic [DIV_W-1:0] w_da_next;
    logic [DIV_W-1:0] w_k;
    logic [DIV_W:0]   w_thresh;

    // A disabled channel parks at idle, so every edge is a period start.
    always_comb begin
        w_start   = (r_p == c_IDLE) || (r_p == (r_da - DIV_W'(1)));
        w_da_next = r_pend ? r_dp : r_da;
        w_enabled = (w_da_next >= DIV_W'(2));
        w_k       = r_p + DIV_W'(1);
        w_thresh  = (DIV_W+1)'(duty_threshold(32'(r_da)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_da   <= c_RST_DIV;
            r_dp   <= c_RST_DIV;
            r_pend <= 1'b0;
            r_p    <= c_IDLE;
            r_out  <= 1'b0;
        end else begin
            if (w_start) begin
                r_da   <= w_da_next;
                r_pend <= 1'b0;
                r_p    <= w_enabled ? '0 : c_IDLE;
                r_out  <= w_enabled;
            end else begin
                r_p    <= w_k;
                r_out  <= ({1'b0, w_k} < w_thresh);
            end
            // Writes are only granted while pend is clear, so this never races the apply above.
            if (wr_en) begin
                r_dp   <= wr_div;
                r_pend <= 1'b1;
            end
        end
    end

    assign pend    = r_pend;
    assign div_out = r_out;

`ifdef CLK_DIV_MULTI_TICK_EN
    logic r_tick;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_start & w_enabled;
        end
    end

    assign tick = r_tick;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module : clk_div_multi
// Brief  : NUM_CH runtime-programmable clock dividers with a valid/ready divisor
//          port. Define CLK_DIV_MULTI_TICK_EN to add per-channel tick outputs.
// Rev    : 1.0
// ============================================================================
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DIV_W  = c_DIV_W_DEF
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    clk_div_multi_if.slave bus
);

    localparam int unsigned c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // The largest reset divisor 2*NUM_CH must fit below the idle phase code.
    if (2 * NUM_CH > (2 ** DIV_W) - 1) begin : g_bad_cfg
        $error("clk_div_multi: 2*NUM_CH must not exceed 2^DIV_W-1");
    end

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_div_out;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic [NUM_CH-1:0] w_tick;
`endif

    // Out-of-range channel numbers match nothing and read as ready.
    always_comb begin
        bus.cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_ch == c_CH_W'(i)) begin
                bus.cfg_ready = ~w_pend[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr_en[i] = bus.cfg_valid & bus.cfg_ready & resetn
                            & (bus.cfg_ch == c_CH_W'(i));

        clk_div_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (reset_div(i))
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (w_wr_en[i]),
            .wr_div  (bus.cfg_div),
            .pend    (w_pend[i]),
            .div_out (w_div_out[i])
`ifdef CLK_DIV_MULTI_TICK_EN
            ,
            .tick    (w_tick[i])
`endif
        );
    end

    assign bus.div_out = w_div_out;
`ifdef CLK_DIV_MULTI_TICK_EN
    assign bus.tick    = w_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_clk_div_multi
// Brief  : Directed self-checking bench for clk_div_multi (NUM_CH=3, DIV_W=4).
// Rev    : 1.0
// ============================================================================
module tb_clk_div_multi;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(3), .DIV_W(4)) bus ();

    clk_div_multi #(.NUM_CH(3), .DIV_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn        = 1'b0;
        bus.cfg_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = 2'd0;
        bus.cfg_div   = 4'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.div_out !== 3'b000) begin
                errors++;
                $display("FAIL reset_div_out cyc %0d: got %b want 000", c, bus.div_out);
            end
`ifdef CLK_DIV_MULTI_TICK_EN
            checks++;
            if (bus.tick !== 3'b000) begin
                errors++;
                $display("FAIL reset_tick cyc %0d: got %b want 000", c, bus.tick);
            end
`endif
        end
        bus.cfg_ch = 2'd3;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_out_of_range: got %b want 1", bus.cfg_ready);
        end
        bus.cfg_ch = 2'd0;
    endtask

    task automatic test_defaults();
        logic [2:0] exp_tab [12];
        exp_tab = '{3'b111, 3'b110, 3'b101, 3'b000, 3'b011, 3'b010,
                    3'b101, 3'b100, 3'b111, 3'b010, 3'b001, 3'b000};
        resetn = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            checks++;
            if (bus.div_out !== exp_tab[e]) begin
                errors++;
                $display("FAIL defaults edge %0d: got %b want %b", e + 1, bus.div_out, exp_tab[e]);
            end
        end
    endtask

    task automatic test_midperiod();
        logic [2:0] exp_tab [14];
        exp_tab = '{3'b111, 3'b110, 3'b101, 3'b000, 3'b011, 3'b010, 3'b111,
                    3'b100, 3'b101, 3'b010, 3'b011, 3'b010, 3'b101, 3'b100};
        apply_reset();
        for (int e = 1; e <= 14; e++) begin
            step();
            checks++;
            if (bus.div_out !== exp_tab[e-1]) begin
                errors++;
                $display("FAIL midperiod edge %0d: got %b want %b", e, bus.div_out, exp_tab[e-1]);
            end
            if (e == 1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_ch    = 2'd1;
                bus.cfg_div   = 4'd5;
                #1;
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midperiod_ready_idle: got %b want 1", bus.cfg_ready);
                end
            end
            if (e == 2) begin
                bus.cfg_valid = 1'b0;
                checks++;
                if (bus.cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL midperiod_ready_pend: got %b want 0", bus.cfg_ready);
                end
                bus.cfg_ch = 2'd3;
                #1;
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midperiod_ready_oor: got %b want 1", bus.cfg_ready);
                end
                bus.cfg_ch = 2'd1;
            end
            if (e == 5) begin
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midperiod_ready_applied: got %b want 1", bus.cfg_ready);
                end
            end
        end
    endtask

    task automatic test_disable();
        logic exp_ch2 [15];
        exp_ch2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int e = 1; e <= 15; e++) begin
            step();
            checks++;
            if (bus.div_out[2] !== exp_ch2[e-1]) begin
                errors++;
                $display("FAIL disable ch2 edge %0d: got %b want %b", e, bus.div_out[2], exp_ch2[e-1]);
            end
            if (e == 1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_ch    = 2'd2;
                bus.cfg_div   = 4'd0;
            end
            if (e == 2) bus.cfg_valid = 1'b0;
            if (e == 8) begin
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL disable_ready: got %b want 1", bus.cfg_ready);
                end
                bus.cfg_valid = 1'b1;
                bus.cfg_div   = 4'd3;
            end
            if (e == 9) bus.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_tab [3];
        exp_tab = '{3'b111, 3'b110, 3'b101};
        apply_reset();
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (bus.div_out !== exp_tab[e-1]) begin
                errors++;
                $display("FAIL resetmid_pre edge %0d: got %b want %b", e, bus.div_out, exp_tab[e-1]);
            end
            if (e == 2) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_ch    = 2'd0;
                bus.cfg_div   = 4'd5;
            end
        end
        bus.cfg_valid = 1'b0;
        resetn        = 1'b0;
        step();
        checks++;
        if (bus.div_out !== 3'b000) begin
            errors++;
            $display("FAIL resetmid_low: got %b want 000", bus.div_out);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pend_cleared: got %b want 1", bus.cfg_ready);
        end
        resetn  = 1'b1;
        exp_tab = '{3'b111, 3'b110, 3'b101};
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (bus.div_out !== exp_tab[e-1]) begin
                errors++;
                $display("FAIL resetmid_post edge %0d: got %b want %b", e, bus.div_out, exp_tab[e-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ch1 [17];
        logic exp_rdy [17];
        exp_ch1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        bus.cfg_ch = 2'd1;
        for (int e = 1; e <= 17; e++) begin
            step();
            checks++;
            if (bus.div_out[1] !== exp_ch1[e-1]) begin
                errors++;
                $display("FAIL b2b ch1 edge %0d: got %b want %b", e, bus.div_out[1], exp_ch1[e-1]);
            end
            checks++;
            if (bus.cfg_ready !== exp_rdy[e-1]) begin
                errors++;
                $display("FAIL b2b ready edge %0d: got %b want %b", e, bus.cfg_ready, exp_rdy[e-1]);
            end
`ifdef CLK_DIV_MULTI_TICK_EN
            begin
                logic exp_tick;
                exp_tick = exp_ch1[e-1] & ((e == 1) ? 1'b1 : ~exp_ch1[e-2]);
                checks++;
                if (bus.tick[1] !== exp_tick) begin
                    errors++;
                    $display("FAIL b2b tick1 edge %0d: got %b want %b", e, bus.tick[1], exp_tick);
                end
            end
`endif
            case (e)
                1:  begin bus.cfg_valid = 1'b1; bus.cfg_div = 4'd6; end
                2:  bus.cfg_valid = 1'b0;
                5:  begin bus.cfg_valid = 1'b1; bus.cfg_div = 4'd3; end
                6:  bus.cfg_div = 4'd2;
                12: bus.cfg_valid = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_write_in_reset();
        logic exp_ch0 [6];
        exp_ch0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        resetn        = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_div   = 4'd7;
        step();
        step();
        bus.cfg_valid = 1'b0;
        resetn        = 1'b1;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_in_reset_ready: got %b want 1", bus.cfg_ready);
        end
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++;
            if (bus.div_out[0] !== exp_ch0[e-1]) begin
                errors++;
                $display("FAIL wr_in_reset ch0 edge %0d: got %b want %b", e, bus.div_out[0], exp_ch0[e-1]);
            end
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = 2'd0;
        bus.cfg_div   = 4'd0;
        test_reset();
        test_defaults();
        test_midperiod();
        test_disable();
        test_reset_mid();
        test_back_to_back();
        test_write_in_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
